alu_muldiv_seq: RTL and testbench

- Iterative sequencer that implements MUL (low 32 bits), DIVU and REMU by driving the shared 32-bit ALU one operation per cycle.
- It issues the ALU's a/b/ALUctrl inputs and consumes its result.
- It sits beside the execute stage. The core hands it one operation through a valid/ready handshake and receives a one-cycle done pulse with the result.

---
 rtl/alu_muldiv_seq.sv | 235 +++++++++++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq
// Iterative MUL (low 32 bits) / DIVU / REMU sequencer that borrows the shared
// 32-bit ALU for one operation per cycle. MUL is a shift-and-add over 32
// steps. DIVU/REMU is restoring division with a compare (SLTU) cycle and a
// subtract (SUB) cycle per quotient bit, so both always take the same time.
//
// Ports
//   clk, reset           rising-edge clock, asynchronous active-high reset
//   start_valid/ready    request handshake (see below)
//   op                   00 MUL, 01 DIVU, 10 REMU, 11 reserved (result 0)
//   opa, opb             multiplicand/dividend, multiplier/divisor
//   busy                 high in every state except IDLE
//   done                 one-cycle pulse; result is valid in that cycle
//   result               registered result, held between operations
//   alu_a/alu_b/alu_ctrl operands and opcode driven to the shared ALU
//   alu_result           combinational ALU result for the current drive
//   dbg_state            current FSM state, for debug and checkers
//
// Handshake: start_ready is high only in IDLE. A request is accepted on a
// rising edge where start_valid && start_ready; op/opa/opb are sampled on that
// edge only. start_valid is ignored while busy and nothing is queued.
//
// The ALU drive is registered and depends on state only, never on
// start_valid, so the ALU can be muxed to the core whenever busy is low.

module alu_muldiv_seq #(
    parameter bit MUL_EARLY_EXIT = 1'b0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [1:0]  op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_ctrl,
    input  logic [31:0] alu_result,
    output logic [2:0]  dbg_state
);

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_MUL_STEP = 3'd1,
        S_DIV_CMP  = 3'd2,
        S_DIV_SUB  = 3'd3,
        S_DONE     = 3'd4
    } state_t;

    state_t      state;
    logic [5:0]  cnt;
    logic [31:0] acc;
    logic [31:0] mcand;
    logic [31:0] mplier;
    logic [31:0] rem;
    logic [31:0] dvd;
    logic [31:0] q;
    logic [31:0] divisor;
    logic [31:0] shifted;
    logic        ge;
    logic        is_rem;

    logic [31:0] acc_next;
    logic [31:0] mcand_next;
    logic [31:0] mplier_next;
    logic [32:0] shifted_full;
    logic        cmp_ge;
    logic [31:0] rem_next;
    logic [31:0] q_next;
    logic        mul_last;
    logic        div_last;

    assign dbg_state = state;

    // MUL step: the ALU is adding acc + mcand; keep the sum only when the
    // current multiplier bit is set.
    assign acc_next    = mplier[0] ? alu_result : acc;
    assign mcand_next  = mcand << 1;
    assign mplier_next = mplier >> 1;
    assign mul_last    = (cnt == 6'd31) || (MUL_EARLY_EXIT && (mplier_next == 32'd0));

    // Division: the partial remainder shifted left is 33 bits wide. When its
    // top bit is set it exceeds any 32-bit divisor, which the 32-bit SLTU
    // cannot see, so that bit forces ge. The 32-bit SUB then wraps to the
    // correct remainder.
    assign shifted_full = {rem, dvd[31]};
    assign cmp_ge       = shifted_full[32] | ~alu_result[0];
    assign rem_next     = ge ? alu_result : shifted;
    assign q_next       = {q[30:0], ge};
    assign div_last     = (cnt == 6'd31);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt         <= 6'd0;
            acc         <= 32'd0;
            mcand       <= 32'd0;
            mplier      <= 32'd0;
            rem         <= 32'd0;
            dvd         <= 32'd0;
            q           <= 32'd0;
            divisor     <= 32'd0;
            shifted     <= 32'd0;
            ge          <= 1'b0;
            is_rem      <= 1'b0;
            result      <= 32'd0;
            done        <= 1'b0;
            start_ready <= 1'b1;
            busy        <= 1'b0;
            alu_a       <= 32'd0;
            alu_b       <= 32'd0;
            alu_ctrl    <= ALU_ADD;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_valid) begin
                        start_ready <= 1'b0;
                        busy        <= 1'b1;
                        cnt         <= 6'd0;
                        case (op)
                            2'b00: begin
                                acc      <= 32'd0;
                                mcand    <= opa;
                                mplier   <= opb;
                                alu_a    <= 32'd0;
                                alu_b    <= opa;
                                alu_ctrl <= ALU_ADD;
                                state    <= S_MUL_STEP;
                            end
                            2'b01, 2'b10: begin
                                if (opb == 32'd0) begin
                                    result <= (op == 2'b01) ? 32'hFFFF_FFFF : opa;
                                    done   <= 1'b1;
                                    state  <= S_DONE;
                                end else begin
                                    rem      <= 32'd0;
                                    dvd      <= opa;
                                    q        <= 32'd0;
                                    divisor  <= opb;
                                    is_rem   <= (op == 2'b10);
                                    // First compare operand: {rem=0, dividend MSB}.
                                    alu_a    <= {31'd0, opa[31]};
                                    alu_b    <= opb;
                                    alu_ctrl <= ALU_SLTU;
                                    state    <= S_DIV_CMP;
                                end
                            end
                            default: begin
                                result <= 32'd0;
                                done   <= 1'b1;
                                state  <= S_DONE;
                            end
                        endcase
                    end
                end

                S_MUL_STEP: begin
                    acc    <= acc_next;
                    mcand  <= mcand_next;
                    mplier <= mplier_next;
                    cnt    <= cnt + 6'd1;
                    if (mul_last) begin
                        result   <= acc_next;
                        done     <= 1'b1;
                        alu_a    <= 32'd0;
                        alu_b    <= 32'd0;
                        alu_ctrl <= ALU_ADD;
                        state    <= S_DONE;
                    end else begin
                        alu_a    <= acc_next;
                        alu_b    <= mcand_next;
                        alu_ctrl <= ALU_ADD;
                    end
                end

                S_DIV_CMP: begin
                    ge       <= cmp_ge;
                    shifted  <= shifted_full[31:0];
                    dvd      <= dvd << 1;
                    alu_a    <= shifted_full[31:0];
                    alu_b    <= divisor;
                    alu_ctrl <= ALU_SUB;
                    state    <= S_DIV_SUB;
                end

                S_DIV_SUB: begin
                    rem <= rem_next;
                    q   <= q_next;
                    cnt <= cnt + 6'd1;
                    if (div_last) begin
                        result   <= is_rem ? rem_next : q_next;
                        done     <= 1'b1;
                        alu_a    <= 32'd0;
                        alu_b    <= 32'd0;
                        alu_ctrl <= ALU_ADD;
                        state    <= S_DONE;
                    end else begin
                        // dvd was already shifted in DIV_CMP, so dvd[31] is
                        // the next dividend bit to bring down.
                        alu_a    <= {rem_next[30:0], dvd[31]};
                        alu_b    <= divisor;
                        alu_ctrl <= ALU_SLTU;
                        state    <= S_DIV_CMP;
                    end
                end

                S_DONE: begin
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                    state       <= S_IDLE;
                end

                default: begin
                    done        <= 1'b0;
                    busy        <= 1'b0;
                    start_ready <= 1'b1;
                    alu_a       <= 32'd0;
                    alu_b       <= 32'd0;
                    alu_ctrl    <= ALU_ADD;
                    state       <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Testbench for alu_muldiv_seq. Two instances share clock and reset: dut
// (MUL_EARLY_EXIT = 0) and dut_ee (MUL_EARLY_EXIT = 1). Each has a small
// behavioural ALU. Drivers push the expected result, latency and acceptance
// cycle into queues. Monitors pop and compare on every done pulse.

module tb_alu_muldiv_seq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // ---------------- DUT (no early exit) ----------------
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] opa = 32'd0;
    logic [31:0] opb = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_ctrl;
    logic [31:0] alu_result;
    logic [2:0]  dbg_state;

    alu_muldiv_seq #(.MUL_EARLY_EXIT(1'b0)) dut (
        .clk(clk), .reset(reset),
        .start_valid(start_valid), .start_ready(start_ready),
        .op(op), .opa(opa), .opb(opb),
        .busy(busy), .done(done), .result(result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .dbg_state(dbg_state)
    );

    // ---------------- DUT (early exit) ----------------
    logic        ee_valid = 1'b0;
    logic        ee_ready;
    logic [1:0]  ee_op = 2'b00;
    logic [31:0] ee_a = 32'd0;
    logic [31:0] ee_b = 32'd0;
    logic        ee_busy;
    logic        ee_done;
    logic [31:0] ee_result;
    logic [31:0] ee_alu_a;
    logic [31:0] ee_alu_b;
    logic [3:0]  ee_alu_ctrl;
    logic [31:0] ee_alu_result;
    logic [2:0]  ee_dbg_state;

    alu_muldiv_seq #(.MUL_EARLY_EXIT(1'b1)) dut_ee (
        .clk(clk), .reset(reset),
        .start_valid(ee_valid), .start_ready(ee_ready),
        .op(ee_op), .opa(ee_a), .opb(ee_b),
        .busy(ee_busy), .done(ee_done), .result(ee_result),
        .alu_a(ee_alu_a), .alu_b(ee_alu_b), .alu_ctrl(ee_alu_ctrl),
        .alu_result(ee_alu_result), .dbg_state(ee_dbg_state)
    );

    // ---------------- ALU model ----------------
    function automatic logic [31:0] alu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [3:0] c);
        case (c)
            4'b0000: return a + b;
            4'b0001: return a - b;
            4'b1001: return {31'd0, (a < b)};
            default: return 32'd0;
        endcase
    endfunction

    assign alu_result    = alu_model(alu_a, alu_b, alu_ctrl);
    assign ee_alu_result = alu_model(ee_alu_a, ee_alu_b, ee_alu_ctrl);

    // ---------------- reference model ----------------
    function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a,
                                               input logic [31:0] b);
        logic [63:0] p;
        case (o)
            2'b00: begin
                p = 64'(a) * 64'(b);
                return p[31:0];
            end
            2'b01: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            2'b10: return (b == 32'd0) ? a : a % b;
            default: return 32'd0;
        endcase
    endfunction

    // Cycles from acceptance to the done cycle.
    function automatic int ref_latency(input logic [1:0] o, input logic [31:0] b, input bit early);
        int steps;
        if (o == 2'b00) begin
            if (!early) return 33;
            // Early exit: one step per multiplier bit up to the highest set
            // bit; a zero multiplier still takes one step.
            steps = 1;
            for (int i = 0; i < 32; i++) if (b[i]) steps = i + 1;
            return steps + 1;
        end
        if (o == 2'b11 || b == 32'd0) return 1;
        return 65;
    endfunction

    // ---------------- scoreboard queues ----------------
    logic [31:0] exp_q[$];
    int          lat_q[$];
    int          acc_q[$];
    logic [31:0] ee_exp_q[$];
    int          ee_lat_q[$];
    int          ee_acc_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Returns at the falling edge of cycle 1 after acceptance.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        start_valid = 1'b1;
        op = o; opa = a; opb = b;
        while (!start_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!start_ready) begin
            checks++; errors++;
            $display("FAIL issue_timeout actual=ready_low expected=ready_high");
            start_valid = 1'b0;
            return;
        end
        exp_q.push_back(ref_result(o, a, b));
        lat_q.push_back(ref_latency(o, b, 1'b0));
        acc_q.push_back(cyc);
        @(negedge clk);
        start_valid = 1'b0;
    endtask

    task automatic issue_ee(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int waited;
        waited = 0;
        @(negedge clk);
        ee_valid = 1'b1;
        ee_op = o; ee_a = a; ee_b = b;
        while (!ee_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!ee_ready) begin
            checks++; errors++;
            $display("FAIL ee_issue_timeout actual=ready_low expected=ready_high");
            ee_valid = 1'b0;
            return;
        end
        ee_exp_q.push_back(ref_result(o, a, b));
        ee_lat_q.push_back(ref_latency(o, b, 1'b1));
        ee_acc_q.push_back(cyc);
        @(negedge clk);
        ee_valid = 1'b0;
    endtask

    task automatic drain();
        int w;
        w = 0;
        while ((exp_q.size() > 0 || ee_exp_q.size() > 0) && w < 2000) begin
            @(negedge clk);
            w++;
        end
        if (exp_q.size() > 0 || ee_exp_q.size() > 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d expected=0", exp_q.size() + ee_exp_q.size());
        end
        repeat (3) @(negedge clk);
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        logic [31:0] e;
        int          l;
        int          a0;
        if (!reset && done) begin
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_done actual=%0h expected=no_done", result);
            end else begin
                e  = exp_q.pop_front();
                l  = lat_q.pop_front();
                a0 = acc_q.pop_front();
                check("result", result, e);
                check("latency", 32'(cyc - a0), 32'(l));
                check("ready_in_done", {31'd0, start_ready}, 32'd0);
                check("busy_in_done", {31'd0, busy}, 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        logic [31:0] e;
        int          l;
        int          a0;
        if (!reset && ee_done) begin
            if (ee_exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL ee_unexpected_done actual=%0h expected=no_done", ee_result);
            end else begin
                e  = ee_exp_q.pop_front();
                l  = ee_lat_q.pop_front();
                a0 = ee_acc_q.pop_front();
                check("ee_result", ee_result, e);
                check("ee_latency", 32'(cyc - a0), 32'(l));
            end
        end
    end

    // ---------------- watchdog ----------------
    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    // ---------------- main stimulus ----------------
    initial begin
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        int          sel;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, start_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        check("rst_alu_a", alu_a, 32'd0);
        check("rst_alu_b", alu_b, 32'd0);
        reset = 1'b0;

        // MUL 7 x 6 while holding start_valid with other operands.
        issue(2'b00, 32'd7, 32'd6);
        for (int k = 1; k <= 31; k++) begin
            start_valid = 1'b1;
            op = 2'b01; opa = $urandom; opb = 32'd3;
            check("ready_low_busy", {31'd0, start_ready}, 32'd0);
            check("busy_high", {31'd0, busy}, 32'd1);
            @(negedge clk);
        end
        start_valid = 1'b0;
        check("ready_low_c32", {31'd0, start_ready}, 32'd0);
        @(negedge clk);                       // cycle 33: DONE (monitor)
        @(negedge clk);                       // cycle 34: IDLE
        check("ready_after_done", {31'd0, start_ready}, 32'd1);
        check("busy_after_done", {31'd0, busy}, 32'd0);
        check("alu_ctrl_idle", {28'd0, alu_ctrl}, 32'd0);

        // Directed corner cases.
        issue(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        issue(2'b01, 32'd100, 32'd7);
        issue(2'b10, 32'd100, 32'd7);
        issue(2'b01, 32'hFFFF_FFFF, 32'h8000_0001);
        issue(2'b10, 32'hFFFF_FFFF, 32'h8000_0001);
        issue(2'b01, 32'd5, 32'd0);
        issue(2'b10, 32'd5, 32'd0);
        issue(2'b11, 32'd5, 32'd9);
        issue(2'b01, 32'd3, 32'hFFFF_FFFF);
        drain();

        // Asynchronous reset in cycle 20 of a DIVU.
        issue(2'b01, 32'd1000000, 32'd3);
        repeat (19) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ready", {31'd0, start_ready}, 32'd1);
        check("midrst_result", result, 32'd0);
        check("midrst_done", {31'd0, done}, 32'd0);
        check("midrst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
        exp_q.delete();
        lat_q.delete();
        acc_q.delete();
        @(negedge clk);
        reset = 1'b0;
        issue(2'b00, 32'd3, 32'd4);
        drain();

        // Early-exit instance.
        issue_ee(2'b00, 32'd5, 32'd3);
        issue_ee(2'b00, 32'd9, 32'd0);
        issue_ee(2'b00, 32'd3, 32'h8000_0000);
        issue_ee(2'b01, 32'd100, 32'd7);
        for (int i = 0; i < 6; i++) issue_ee(2'b00, $urandom, 32'($urandom_range(0, 4095)));
        drain();

        // Randomized back-to-back traffic.
        for (int i = 0; i < 40; i++) begin
            ro  = 2'($urandom_range(0, 3));
            ra  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       rb = 32'd0;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = 32'h8000_0000 | $urandom;
                default: rb = $urandom;
            endcase
            issue(ro, ra, rb);
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
